// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// Owns a single memory port and hands it to one requester per transaction,
// alternating priority between requesters that complete. A per-transaction
// watchdog terminates a stuck memory access with a bus-error pulse.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | arbitration cycle; memory port quiet, grant chosen for next BUSY
// BUSY  | granted requester drives memory; waits for data_ready/timeout

`ifndef XLEN
`define XLEN 32
`endif

module dmem_arbiter #(
  parameter int XLEN    = `XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic [XLEN-1:0] i_p0_addr,
  input  logic [XLEN-1:0] i_p0_wd,
  input  logic [3:0]      i_p0_byte_en,
  input  logic            i_p0_wen,
  input  logic            i_p0_rd,

  input  logic [XLEN-1:0] i_p1_addr,
  input  logic [XLEN-1:0] i_p1_wd,
  input  logic [3:0]      i_p1_byte_en,
  input  logic            i_p1_wen,
  input  logic            i_p1_rd,

  output logic            o_p0_ready,
  output logic [XLEN-1:0] o_p0_rdata,
  output logic            o_p1_ready,
  output logic [XLEN-1:0] o_p1_rdata,

  output logic [XLEN-1:0] o_DM_Addr,
  output logic [XLEN-1:0] o_DM_Wd,
  output logic [3:0]      o_DM_byte_en,
  output logic            o_DM_Wen,
  output logic            o_DM_MemRead,

  input  logic            i_DM_data_ready,
  input  logic [XLEN-1:0] i_DM_ReadData,

  output logic            o_grant,
  output logic            o_busy,
  output logic            o_bus_err
);

  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q,  prio_d;
  logic            grant_q, grant_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  logic            req0, req1, req_g;
  logic [XLEN-1:0] g_addr, g_wd;
  logic [3:0]      g_byte_en;
  logic            g_wen, g_rd;

  // done: memory completed this cycle; tmo: watchdog fired this cycle
  logic            done, tmo;

  assign req0 = i_p0_wen | i_p0_rd;
  assign req1 = i_p1_wen | i_p1_rd;

  // Select the request fields of the current owner.
  always_comb begin
    req_g     = req0;
    g_addr    = i_p0_addr;
    g_wd      = i_p0_wd;
    g_byte_en = i_p0_byte_en;
    g_wen     = i_p0_wen;
    g_rd      = i_p0_rd;
    if (grant_q) begin
      req_g     = req1;
      g_addr    = i_p1_addr;
      g_wd      = i_p1_wd;
      g_byte_en = i_p1_byte_en;
      g_wen     = i_p1_wen;
      g_rd      = i_p1_rd;
    end
  end

  // Next-state, grant/priority update, watchdog and memory-side drive.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    done         = 1'b0;
    tmo          = 1'b0;
    o_DM_Addr    = '0;
    o_DM_Wd      = '0;
    o_DM_byte_en = '0;
    o_DM_Wen     = 1'b0;
    o_DM_MemRead = 1'b0;

    case (state_q)
      IDLE: begin
        // data_ready is deliberately ignored here; memory sees nothing
        // until the cycle after arbitration.
        if (req0 | req1) begin
          state_d = BUSY;
          cnt_d   = '0;
          if (req0 & req1) grant_d = prio_q;
          else             grant_d = req1;
        end
      end

      BUSY: begin
        o_DM_Addr    = g_addr;
        o_DM_Wd      = g_wd;
        o_DM_byte_en = g_byte_en;
        o_DM_Wen     = g_wen;
        o_DM_MemRead = g_rd;

        if (!req_g) begin
          // Requester withdrew: drop the transaction silently, keep priority.
          state_d = IDLE;
        end else if (i_DM_data_ready) begin
          // Completion wins over a coincident timeout.
          done    = 1'b1;
          state_d = IDLE;
          prio_d  = ~grant_q;
        end else if (cnt_q == CNT_LAST) begin
          tmo          = 1'b1;
          o_DM_Wen     = 1'b0;
          o_DM_MemRead = 1'b0;
          state_d      = IDLE;
          prio_d       = ~grant_q;
        end else begin
          // Only increments below the terminal value, so it cannot wrap.
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Requester responses; a reset cycle never reports completion.
  always_comb begin
    o_p0_ready = (done | tmo) & ~grant_q & ~i_rst;
    o_p1_ready = (done | tmo) &  grant_q & ~i_rst;
    o_p0_rdata = (tmo & ~grant_q) ? '0 : i_DM_ReadData;
    o_p1_rdata = (tmo &  grant_q) ? '0 : i_DM_ReadData;
    o_bus_err  = tmo & ~i_rst;
    o_grant    = grant_q;
    o_busy     = (state_q == BUSY);
  end

  // State, grant, priority and watchdog registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
